// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot loader that fills the instruction BRAM before the core starts.
//
// A byte stream arrives over a valid/ready handshake. It carries a 4-byte
// little-endian word count followed by that many little-endian 32-bit
// instruction words. Each completed word is written to the BRAM through a
// one-cycle write strobe. The core is held in reset until the whole image
// has been written.
//
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN):
//   The data words are followed by a 4-byte little-endian trailer. The trailer
//   must equal the modulo-2^32 sum of all data words; if it does not, the load
//   is aborted.
//
// Parameters:
//   BASE_ADDR  byte address of the first instruction word
//   MAX_WORDS  instruction memory depth in words; longer images are rejected
//   CNT_WIDTH  width of the word counter and the length register
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   byte_valid     byte_data is valid this cycle
//   byte_data      incoming stream byte
//   byte_ready     loader accepts a byte this cycle
//   imem_we        one-cycle write strobe to the instruction BRAM
//   imem_addr      byte address of the write
//   imem_wdata     instruction word being written
//   words_written  number of words written so far
//   done           image fully loaded
//   err            load aborted
//   cpu_rst_n      active-low core reset, released only on success
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 32000,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    output logic                 imem_we,
    output logic [31:0]          imem_addr,
    output logic [31:0]          imem_wdata,
    output logic [CNT_WIDTH-1:0] words_written,
    output logic                 done,
    output logic                 err,
    output logic                 cpu_rst_n
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_LEN, S_DATA, S_DONE, S_ERR} state_t;
`endif

    state_t                 state;
    logic [1:0]             byte_idx;
    logic [23:0]            asm_buf;
    logic [CNT_WIDTH-1:0]   len;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]            sum;
`endif

    logic                   accept;
    logic                   last_byte;
    logic [31:0]            byte_word;
    logic [CNT_WIDTH-1:0]   next_count;
    logic [31:0]            word_addr;

    // Handshake decode and the word that completes when the current byte is
    // the fourth one. asm_buf shifts right, so after three bytes it holds
    // {b2, b1, b0} and the incoming byte lands on top: little-endian order.
    always_comb begin
        accept     = byte_valid && byte_ready;
        last_byte  = accept && (byte_idx == 2'd3);
        byte_word  = {byte_data, asm_buf};
        next_count = words_written + CNT_WIDTH'(1);
        word_addr  = BASE_ADDR + (32'(words_written) << 2);
    end

    // Single loader FSM with registered outputs. byte_ready is registered
    // from the next state, so it drops on the same edge that takes the final
    // byte. done and cpu_rst_n rise on that edge too, so they appear together
    // with the last write strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_LEN;
            byte_idx      <= 2'd0;
            asm_buf       <= 24'd0;
            len           <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum           <= 32'd0;
`endif
            byte_ready    <= 1'b0;
            imem_we       <= 1'b0;
            imem_addr     <= BASE_ADDR;
            imem_wdata    <= 32'd0;
            words_written <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            cpu_rst_n     <= 1'b0;
        end else begin
            imem_we <= 1'b0;

            if (accept) begin
                asm_buf  <= {byte_data, asm_buf[23:8]};
                byte_idx <= byte_idx + 2'd1;
            end

            case (state)
                S_LEN: begin
                    byte_ready <= 1'b1;
                    if (last_byte) begin
                        len <= CNT_WIDTH'(byte_word);
                        if (byte_word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= S_CHK;
`else
                            state      <= S_DONE;
                            byte_ready <= 1'b0;
                            done       <= 1'b1;
                            cpu_rst_n  <= 1'b1;
`endif
                        end else if (byte_word > MAX_WORDS) begin
                            state      <= S_ERR;
                            byte_ready <= 1'b0;
                            err        <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    byte_ready <= 1'b1;
                    if (last_byte) begin
                        imem_we       <= 1'b1;
                        imem_wdata    <= byte_word;
                        imem_addr     <= word_addr;
                        words_written <= next_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum <= sum + byte_word;
`endif
                        if (next_count == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= S_CHK;
`else
                            state      <= S_DONE;
                            byte_ready <= 1'b0;
                            done       <= 1'b1;
                            cpu_rst_n  <= 1'b1;
`endif
                        end
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                // Trailer compare. Words already written stay in the BRAM on
                // a mismatch; only the core release is withheld.
                S_CHK: begin
                    byte_ready <= 1'b1;
                    if (last_byte) begin
                        byte_ready <= 1'b0;
                        if (byte_word == sum) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif

                S_DONE: begin
                    byte_ready <= 1'b0;
                    done       <= 1'b1;
                    cpu_rst_n  <= 1'b1;
                end

                S_ERR: begin
                    byte_ready <= 1'b0;
                    err        <= 1'b1;
                    cpu_rst_n  <= 1'b0;
                end

                default: begin
                    state      <= S_ERR;
                    byte_ready <= 1'b0;
                    err        <= 1'b1;
                    cpu_rst_n  <= 1'b0;
                end
            endcase
        end
    end

endmodule
